// File: rtl/wrr_lock_arbiter_if.sv
// rtl/wrr_lock_arbiter_if.sv - request/payload bundle and output channel of the WRR lock arbiter
interface wrr_lock_arbiter_if #(
  parameter int NUM_REQ  = 8,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]          req_i;
  logic [NUM_REQ*DATA_W-1:0]   data_i;
  logic [NUM_REQ*WEIGHT_W-1:0] weight_i;
  logic                        ready_i;
  logic [NUM_REQ-1:0]          gnt_o;
  logic                        vld_o;
  logic [DATA_W-1:0]           data_o;
  logic [IDX_W-1:0]            idx_o;

  modport master (
    output req_i, data_i, weight_i, ready_i,
    input  gnt_o, vld_o, data_o, idx_o
  );

  modport slave (
    input  req_i, data_i, weight_i, ready_i,
    output gnt_o, vld_o, data_o, idx_o
  );
endinterface

// File: rtl/wrr_lock_arbiter.sv
// rtl/wrr_lock_arbiter.sv - weighted round-robin arbiter with stall lock-in and payload mux
module wrr_lock_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4,
  parameter bit LOCK_IN  = 1'b1,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  wrr_lock_arbiter_if.slave bus
);

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic                locked_q, locked_d;
  logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;

  logic [IDX_W-1:0]    hi_sel, lo_sel, sel;
  logic                hi_any, vld, xfer, lock_hit;
  logic [WEIGHT_W-1:0] wsel, eff_cnt;
  logic [NUM_REQ-1:0]  gnt;

  // Downward scan leaves the lowest match: hi_sel is the first at/after ptr, lo_sel the wrap-around one.
  always_comb begin
    hi_sel = '0;
    lo_sel = '0;
    hi_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[IDX_W'(i)]) begin
        lo_sel = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_sel = IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign lock_hit = LOCK_IN && locked_q && bus.req_i[lock_idx_q];
  assign sel      = lock_hit ? lock_idx_q : (hi_any ? hi_sel : lo_sel);
  assign vld      = |bus.req_i;
  assign xfer     = vld && bus.ready_i;

  always_comb begin
    gnt = '0;
    if (xfer) gnt[sel] = 1'b1;
  end

  assign bus.vld_o  = vld;
  assign bus.gnt_o  = gnt;
  assign bus.idx_o  = vld ? sel : '0;
  assign bus.data_o = vld ? bus.data_i[sel*DATA_W +: DATA_W] : '0;

  assign wsel    = bus.weight_i[sel*WEIGHT_W +: WEIGHT_W];
  assign eff_cnt = (sel == ptr_q) ? cnt_q : '0;

  // A transfer from anyone other than ptr restarts counting, which abandons the old burst.
  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      ptr_d    = '0;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (xfer) begin
      locked_d = 1'b0;
      if (eff_cnt >= wsel) begin
        ptr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        cnt_d = '0;
      end else begin
        ptr_d = sel;
        cnt_d = eff_cnt + 1'b1;
      end
    end else if (LOCK_IN && vld) begin
      locked_d   = 1'b1;
      lock_idx_d = sel;
    end else begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // A locked requester must hold its request until it transfers.
  a_lock_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    !(locked_q && !bus.req_i[lock_idx_q]));

endmodule
